// File: rtl/qmem_width_bridge_pkg.sv
// Shared definitions for the QMEM width-down-converting bridge:
// FSM state encoding, a constant log2 helper and the lane-order mapping.
package qmem_width_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_DONE = 2'd2
    } qmem_state_e;

    // Ceiling log2 for elaboration-time width calculations.
    function automatic int qmem_clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Master lane carried by a given slave beat. With big-endian ordering the
    // most-significant lane goes out first, at the lowest slave address.
    function automatic int qmem_lane(input int beat, input int ratio, input int big_endian);
        return (big_endian != 0) ? (ratio - 1 - beat) : beat;
    endfunction

endpackage

// File: rtl/qmem_width_bridge_beat_sel.sv
// Next-needed-beat priority encoder. Finds the lowest beat index above `cur`
// (or from 0 when `first` is set) whose byte-select slice is non-empty; with
// SKIP_EMPTY=0 every beat counts as needed.
module qmem_beat_sel
    import qmem_width_bridge_pkg::*;
#(
    parameter int MSW        = 4,
    parameter int SSW        = 2,
    parameter int RATIO      = 2,
    parameter int BW         = 1,
    parameter int BIG_ENDIAN = 1,
    parameter int SKIP_EMPTY = 1
) (
    input  logic [MSW-1:0] sel,
    input  logic [BW-1:0]  cur,
    input  logic           first,
    output logic           found,
    output logic [BW-1:0]  nxt
);

    logic [RATIO-1:0] need_s;

    genvar g;
    for (g = 0; g < RATIO; g = g + 1) begin : g_need
        localparam int LANE = qmem_lane(g, RATIO, BIG_ENDIAN);
        assign need_s[g] = (SKIP_EMPTY != 0) ? (|sel[LANE*SSW +: SSW]) : 1'b1;
    end

    // Scan from the top down so the lowest qualifying index is the one kept.
    always_comb begin
        found = 1'b0;
        nxt   = '0;
        for (int i = RATIO - 1; i >= 0; i--) begin
            found = found | (need_s[i] & (first | (i > int'(cur))));
            nxt   = (need_s[i] & (first | (i > int'(cur)))) ? BW'(i) : nxt;
        end
    end

endmodule

// File: rtl/qmem_width_bridge.sv
// QMEM width-down-converting bridge. One wide master access is split into up
// to RATIO narrow slave beats (empty beats optionally skipped); read data is
// reassembled lane by lane, and slave errors or a per-beat timeout complete
// the access early with m_err set. All outputs are registered.
module qmem_width_bridge
    import qmem_width_bridge_pkg::*;
#(
    parameter int AW         = 22,
    parameter int MDW        = 32,
    parameter int SDW        = 16,
    parameter int MSW        = MDW / 8,
    parameter int SSW        = SDW / 8,
    parameter int BIG_ENDIAN = 1,
    parameter int SKIP_EMPTY = 1,
    parameter int TO_W       = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [AW-1:0]  m_adr,
    input  logic           m_cs,
    input  logic           m_we,
    input  logic [MSW-1:0] m_sel,
    input  logic [MDW-1:0] m_dat_w,
    output logic [MDW-1:0] m_dat_r,
    output logic           m_ack,
    output logic           m_err,
    output logic [AW-1:0]  s_adr,
    output logic           s_cs,
    output logic           s_we,
    output logic [SSW-1:0] s_sel,
    output logic [SDW-1:0] s_dat_w,
    input  logic [SDW-1:0] s_dat_r,
    input  logic           s_ack,
    input  logic           s_err
);

    localparam int RATIO     = MDW / SDW;
    localparam int BW        = qmem_clog2(RATIO);
    localparam int SLOG      = qmem_clog2(SSW);
    localparam int MLOG      = qmem_clog2(MSW);
    localparam int HW        = AW - MLOG;
    localparam int TO_CW     = (TO_W > 0) ? TO_W : 1;
    localparam int TO_LAST_I = (TO_CW > 1) ? ((1 << TO_CW) - 2) : 0;
    localparam logic [TO_CW-1:0] TO_LAST = TO_CW'(TO_LAST_I);

    // Slave address of a beat: master word address, beat index, zero byte offset.
    function automatic logic [AW-1:0] beat_adr(input logic [HW-1:0] hi, input logic [BW-1:0] beat);
        logic [AW-1:0] a;
        a = '0;
        a[AW-1:SLOG] = {hi, beat};
        return a;
    endfunction

    qmem_state_e    state_r, state_nxt_s;
    logic [HW-1:0]  adr_hi_r, adr_hi_nxt_s;
    logic           we_r, we_nxt_s;
    logic [MSW-1:0] sel_r, sel_nxt_s;
    logic [MDW-1:0] dat_w_r, dat_w_nxt_s;
    logic [BW-1:0]  beat_r, beat_nxt_s;
    logic [TO_CW-1:0] to_cnt_r, to_cnt_nxt_s;

    logic [MDW-1:0] m_dat_r_nxt_s;
    logic           m_ack_nxt_s, m_err_nxt_s;
    logic [AW-1:0]  s_adr_nxt_s;
    logic           s_cs_nxt_s, s_we_nxt_s;
    logic [SSW-1:0] s_sel_nxt_s;
    logic [SDW-1:0] s_dat_w_nxt_s;

    logic           idle_s;
    logic [MSW-1:0] sel_src_s;
    logic [MDW-1:0] dat_src_s;
    logic [HW-1:0]  hi_src_s;
    logic [MLOG-1:0] adr_lo_unused_s;
    logic           found_s;
    logic [BW-1:0]  nxt_beat_s;
    logic [BW-1:0]  ld_lane_s, cur_lane_s;
    logic [AW-1:0]  ld_adr_s;
    logic [SSW-1:0] ld_sel_s;
    logic [SDW-1:0] ld_dat_s;
    logic           to_hit_s;

    // In IDLE the first beat is prepared straight from the master inputs so it
    // can be issued on the cycle after the request is sampled.
    assign idle_s          = (state_r == ST_IDLE);
    assign sel_src_s       = idle_s ? m_sel : sel_r;
    assign dat_src_s       = idle_s ? m_dat_w : dat_w_r;
    assign hi_src_s        = idle_s ? m_adr[AW-1:MLOG] : adr_hi_r;
    assign adr_lo_unused_s = m_adr[MLOG-1:0];

    qmem_beat_sel #(
        .MSW        (MSW),
        .SSW        (SSW),
        .RATIO      (RATIO),
        .BW         (BW),
        .BIG_ENDIAN (BIG_ENDIAN),
        .SKIP_EMPTY (SKIP_EMPTY)
    ) u_beat_sel (
        .sel   (sel_src_s),
        .cur   (beat_r),
        .first (idle_s),
        .found (found_s),
        .nxt   (nxt_beat_s)
    );

    assign ld_lane_s  = BW'(qmem_lane(int'(nxt_beat_s), RATIO, BIG_ENDIAN));
    assign cur_lane_s = BW'(qmem_lane(int'(beat_r), RATIO, BIG_ENDIAN));
    assign ld_adr_s   = beat_adr(hi_src_s, nxt_beat_s);
    assign ld_sel_s   = sel_src_s[ld_lane_s*SSW +: SSW];
    assign ld_dat_s   = dat_src_s[ld_lane_s*SDW +: SDW];
    assign to_hit_s   = (TO_W > 0) && (to_cnt_r == TO_LAST);

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_nxt_s   = state_r;
        adr_hi_nxt_s  = adr_hi_r;
        we_nxt_s      = we_r;
        sel_nxt_s     = sel_r;
        dat_w_nxt_s   = dat_w_r;
        beat_nxt_s    = beat_r;
        to_cnt_nxt_s  = to_cnt_r;
        m_dat_r_nxt_s = m_dat_r;
        m_ack_nxt_s   = 1'b0;
        m_err_nxt_s   = 1'b0;
        s_adr_nxt_s   = s_adr;
        s_cs_nxt_s    = s_cs;
        s_we_nxt_s    = s_we;
        s_sel_nxt_s   = s_sel;
        s_dat_w_nxt_s = s_dat_w;
        case (state_r)
            ST_IDLE: begin
                if (m_cs) begin
                    adr_hi_nxt_s  = m_adr[AW-1:MLOG];
                    we_nxt_s      = m_we;
                    sel_nxt_s     = m_sel;
                    dat_w_nxt_s   = m_dat_w;
                    m_dat_r_nxt_s = '0;
                    to_cnt_nxt_s  = '0;
                    if (found_s) begin
                        state_nxt_s   = ST_BEAT;
                        beat_nxt_s    = nxt_beat_s;
                        s_cs_nxt_s    = 1'b1;
                        s_we_nxt_s    = m_we;
                        s_adr_nxt_s   = ld_adr_s;
                        s_sel_nxt_s   = ld_sel_s;
                        s_dat_w_nxt_s = ld_dat_s;
                    end else begin
                        // Fully masked access: complete without touching the slave.
                        state_nxt_s = ST_DONE;
                        s_cs_nxt_s  = 1'b0;
                        m_ack_nxt_s = 1'b1;
                    end
                end else begin
                    s_cs_nxt_s = 1'b0;
                end
            end
            ST_BEAT: begin
                if (s_err) begin
                    // Error wins over a simultaneous ack; remaining beats dropped.
                    state_nxt_s = ST_DONE;
                    s_cs_nxt_s  = 1'b0;
                    m_ack_nxt_s = 1'b1;
                    m_err_nxt_s = 1'b1;
                end else if (s_ack) begin
                    m_dat_r_nxt_s[cur_lane_s*SDW +: SDW] = s_dat_r;
                    if (found_s) begin
                        beat_nxt_s    = nxt_beat_s;
                        to_cnt_nxt_s  = '0;
                        s_adr_nxt_s   = ld_adr_s;
                        s_sel_nxt_s   = ld_sel_s;
                        s_dat_w_nxt_s = ld_dat_s;
                    end else begin
                        state_nxt_s = ST_DONE;
                        s_cs_nxt_s  = 1'b0;
                        m_ack_nxt_s = 1'b1;
                    end
                end else if (to_hit_s) begin
                    state_nxt_s = ST_DONE;
                    s_cs_nxt_s  = 1'b0;
                    m_ack_nxt_s = 1'b1;
                    m_err_nxt_s = 1'b1;
                end else begin
                    to_cnt_nxt_s = to_cnt_r + 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                s_cs_nxt_s  = 1'b0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                s_cs_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, latched request and registered outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            adr_hi_r <= '0;
            we_r     <= 1'b0;
            sel_r    <= '0;
            dat_w_r  <= '0;
            beat_r   <= '0;
            to_cnt_r <= '0;
            m_dat_r  <= '0;
            m_ack    <= 1'b0;
            m_err    <= 1'b0;
            s_adr    <= '0;
            s_cs     <= 1'b0;
            s_we     <= 1'b0;
            s_sel    <= '0;
            s_dat_w  <= '0;
        end else begin
            state_r  <= state_nxt_s;
            adr_hi_r <= adr_hi_nxt_s;
            we_r     <= we_nxt_s;
            sel_r    <= sel_nxt_s;
            dat_w_r  <= dat_w_nxt_s;
            beat_r   <= beat_nxt_s;
            to_cnt_r <= to_cnt_nxt_s;
            m_dat_r  <= m_dat_r_nxt_s;
            m_ack    <= m_ack_nxt_s;
            m_err    <= m_err_nxt_s;
            s_adr    <= s_adr_nxt_s;
            s_cs     <= s_cs_nxt_s;
            s_we     <= s_we_nxt_s;
            s_sel    <= s_sel_nxt_s;
            s_dat_w  <= s_dat_w_nxt_s;
        end
    end

endmodule

// File: tb/tb_qmem_width_bridge.sv
// Directed scoreboard bench for qmem_width_bridge: a 32->16 big-endian
// instance and a 64->16 little-endian instance, both with a 4-bit timeout.
module tb_qmem_width_bridge;

    typedef struct {
        logic [21:0] adr;
        logic [1:0]  sel;
        logic        we;
        logic [15:0] dat;
    } beat_t;

    typedef struct {
        logic [63:0] dat;
        logic        chk_dat;
        logic        err;
        int          cyc;
        int          ncs;
    } done_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc_cnt      = 0;

    beat_t qa_beat[$];
    beat_t qb_beat[$];
    done_t qa_done[$];
    done_t qb_done[$];

    // ---------------- DUT A: 32->16, big-endian ----------------
    logic        a_rst;
    logic [21:0] a_m_adr;
    logic        a_m_cs, a_m_we;
    logic [3:0]  a_m_sel;
    logic [31:0] a_m_dat_w, a_m_dat_r;
    logic        a_m_ack, a_m_err;
    logic [21:0] a_s_adr;
    logic        a_s_cs, a_s_we;
    logic [1:0]  a_s_sel;
    logic [15:0] a_s_dat_w, a_s_dat_r;
    logic        a_s_ack, a_s_err;
    logic [15:0] a_mem [8];
    int          a_mode, a_start, a_ncs, a_ncs_base;

    qmem_width_bridge #(
        .AW(22), .MDW(32), .SDW(16), .BIG_ENDIAN(1), .SKIP_EMPTY(1), .TO_W(4)
    ) dut_a (
        .clk(clk), .rst(a_rst),
        .m_adr(a_m_adr), .m_cs(a_m_cs), .m_we(a_m_we), .m_sel(a_m_sel),
        .m_dat_w(a_m_dat_w), .m_dat_r(a_m_dat_r), .m_ack(a_m_ack), .m_err(a_m_err),
        .s_adr(a_s_adr), .s_cs(a_s_cs), .s_we(a_s_we), .s_sel(a_s_sel),
        .s_dat_w(a_s_dat_w), .s_dat_r(a_s_dat_r), .s_ack(a_s_ack), .s_err(a_s_err)
    );

    // ---------------- DUT B: 64->16, little-endian ----------------
    logic        b_rst;
    logic [21:0] b_m_adr;
    logic        b_m_cs, b_m_we;
    logic [7:0]  b_m_sel;
    logic [63:0] b_m_dat_w, b_m_dat_r;
    logic        b_m_ack, b_m_err;
    logic [21:0] b_s_adr;
    logic        b_s_cs, b_s_we;
    logic [1:0]  b_s_sel;
    logic [15:0] b_s_dat_w, b_s_dat_r;
    logic        b_s_ack, b_s_err;
    logic [15:0] b_mem [8];
    int          b_mode, b_start, b_ncs, b_ncs_base;

    qmem_width_bridge #(
        .AW(22), .MDW(64), .SDW(16), .BIG_ENDIAN(0), .SKIP_EMPTY(1), .TO_W(4)
    ) dut_b (
        .clk(clk), .rst(b_rst),
        .m_adr(b_m_adr), .m_cs(b_m_cs), .m_we(b_m_we), .m_sel(b_m_sel),
        .m_dat_w(b_m_dat_w), .m_dat_r(b_m_dat_r), .m_ack(b_m_ack), .m_err(b_m_err),
        .s_adr(b_s_adr), .s_cs(b_s_cs), .s_we(b_s_we), .s_sel(b_s_sel),
        .s_dat_w(b_s_dat_w), .s_dat_r(b_s_dat_r), .s_ack(b_s_ack), .s_err(b_s_err)
    );

    // Slave models: mode 0 zero-wait ack, 1 error with ack, 2 never respond.
    always_comb begin
        a_s_ack   = a_s_cs && (a_mode != 2);
        a_s_err   = a_s_cs && (a_mode == 1);
        a_s_dat_r = a_mem[a_s_adr[3:1]];
        b_s_ack   = b_s_cs && (b_mode != 2);
        b_s_err   = b_s_cs && (b_mode == 1);
        b_s_dat_r = b_mem[b_s_adr[3:1]];
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void push_beat(input int id, input logic [21:0] adr, input logic [1:0] sel,
                                      input logic we, input logic [15:0] dat);
        beat_t e;
        e.adr = adr; e.sel = sel; e.we = we; e.dat = dat;
        if (id == 0) qa_beat.push_back(e); else qb_beat.push_back(e);
    endfunction

    function automatic void push_done(input int id, input logic [63:0] dat, input logic chk_dat,
                                      input logic err, input int cyc, input int ncs);
        done_t e;
        e.dat = dat; e.chk_dat = chk_dat; e.err = err; e.cyc = cyc; e.ncs = ncs;
        if (id == 0) qa_done.push_back(e); else qb_done.push_back(e);
    endfunction

    task automatic check_beat(input int id, input logic [21:0] adr, input logic [1:0] sel,
                              input logic we, input logic [15:0] dat);
        beat_t e;
        string p;
        int    n;
        p = (id == 0) ? "a" : "b";
        n = (id == 0) ? qa_beat.size() : qb_beat.size();
        tests_run++;
        assert (n != 0) else begin
            tests_failed++;
            $error("FAIL %s_beat_unexpected observed adr=%h expected no beat", p, adr);
        end
        if (n != 0) begin
            e = (id == 0) ? qa_beat.pop_front() : qb_beat.pop_front();
            chk({p, "_s_adr"}, 64'(adr), 64'(e.adr));
            chk({p, "_s_sel"}, 64'(sel), 64'(e.sel));
            chk({p, "_s_we"}, 64'(we), 64'(e.we));
            chk({p, "_s_dat_w"}, 64'(dat), 64'(e.dat));
        end
    endtask

    task automatic check_done(input int id, input logic [63:0] dat, input logic err,
                              input logic scs, input int cyc, input int ncs);
        done_t e;
        string p;
        int    n;
        p = (id == 0) ? "a" : "b";
        n = (id == 0) ? qa_done.size() : qb_done.size();
        tests_run++;
        assert (n != 0) else begin
            tests_failed++;
            $error("FAIL %s_ack_unexpected observed m_ack=1 expected m_ack=0", p);
        end
        if (n != 0) begin
            e = (id == 0) ? qa_done.pop_front() : qb_done.pop_front();
            if (e.chk_dat) chk({p, "_m_dat_r"}, dat, e.dat);
            chk({p, "_m_err"}, 64'(err), 64'(e.err));
            chk({p, "_ack_cycle"}, 64'(cyc), 64'(e.cyc));
            chk({p, "_beats_issued"}, 64'(ncs), 64'(e.ncs));
            chk({p, "_s_cs_at_ack"}, 64'(scs), 64'd0);
        end
    endtask

    // Output monitors, sampled on the inactive edge.
    always @(negedge clk) begin
        if (a_s_cs) a_ncs = a_ncs + 1;
        if (a_s_cs && (a_s_ack || a_s_err)) check_beat(0, a_s_adr, a_s_sel, a_s_we, a_s_dat_w);
        if (a_m_ack) check_done(0, 64'(a_m_dat_r), a_m_err, a_s_cs, cyc_cnt - a_start, a_ncs - a_ncs_base);
    end

    always @(negedge clk) begin
        if (b_s_cs) b_ncs = b_ncs + 1;
        if (b_s_cs && (b_s_ack || b_s_err)) check_beat(1, b_s_adr, b_s_sel, b_s_we, b_s_dat_w);
        if (b_m_ack) check_done(1, b_m_dat_r, b_m_err, b_s_cs, cyc_cnt - b_start, b_ncs - b_ncs_base);
    end

    // Issue one master request (called #1 after a rising edge) and wait for m_ack.
    task automatic req(input int id, input logic [21:0] adr, input logic we,
                       input logic [7:0] sel, input logic [63:0] dat);
        bit seen;
        seen = 1'b0;
        if (id == 0) begin
            a_m_adr = adr; a_m_we = we; a_m_sel = sel[3:0]; a_m_dat_w = dat[31:0];
            a_m_cs = 1'b1; a_start = cyc_cnt; a_ncs_base = a_ncs;
        end else begin
            b_m_adr = adr; b_m_we = we; b_m_sel = sel; b_m_dat_w = dat;
            b_m_cs = 1'b1; b_start = cyc_cnt; b_ncs_base = b_ncs;
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((id == 0 && a_m_ack) || (id == 1 && b_m_ack)) begin
                seen = 1'b1;
                break;
            end
        end
        chk((id == 0) ? "a_ack_seen" : "b_ack_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        if (id == 0) a_m_cs = 1'b0; else b_m_cs = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_m_adr = '0; a_m_cs = 1'b0; a_m_we = 1'b0; a_m_sel = '0; a_m_dat_w = '0;
        b_m_adr = '0; b_m_cs = 1'b0; b_m_we = 1'b0; b_m_sel = '0; b_m_dat_w = '0;
        a_mode = 0; b_mode = 0;
        a_start = 0; a_ncs = 0; a_ncs_base = 0;
        b_start = 0; b_ncs = 0; b_ncs_base = 0;
        for (int i = 0; i < 8; i++) begin
            a_mem[i] = 16'h0000;
            b_mem[i] = 16'(16'h1111 * (i + 1));
        end
        a_mem[0] = 16'h1234;
        a_mem[1] = 16'h5678;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("a_rst_s_cs", 64'(a_s_cs), 64'd0);
        chk("a_rst_m_ack", 64'(a_m_ack), 64'd0);
        chk("a_rst_m_dat_r", 64'(a_m_dat_r), 64'd0);
        chk("a_rst_s_adr", 64'(a_s_adr), 64'd0);
        chk("b_rst_s_cs", 64'(b_s_cs), 64'd0);
        chk("b_rst_m_err", 64'(b_m_err), 64'd0);
        @(posedge clk);
        #1;
        a_rst = 1'b0; b_rst = 1'b0;

        // A1: 32->16 big-endian read, two zero-wait beats
        push_beat(0, 22'h000100, 2'b11, 1'b0, 16'hCAFE);
        push_beat(0, 22'h000102, 2'b11, 1'b0, 16'hF00D);
        push_done(0, 64'h0000_0000_1234_5678, 1'b1, 1'b0, 3, 2);
        req(0, 22'h000100, 1'b0, 8'h0F, 64'h0000_0000_CAFE_F00D);

        // A2: write of the low lane only -> one beat at the higher address
        push_beat(0, 22'h000206, 2'b11, 1'b1, 16'hBEEF);
        push_done(0, 64'h0, 1'b0, 1'b0, 2, 1);
        req(0, 22'h000204, 1'b1, 8'h03, 64'h0000_0000_DEAD_BEEF);

        // A3: fully masked write, no slave access
        push_done(0, 64'h0, 1'b1, 1'b0, 1, 0);
        req(0, 22'h000300, 1'b1, 8'h00, 64'h0000_0000_1111_2222);

        // A4: slave error together with ack on beat 0
        a_mode = 1;
        push_beat(0, 22'h000100, 2'b11, 1'b0, 16'h0000);
        push_done(0, 64'h0, 1'b1, 1'b1, 2, 1);
        req(0, 22'h000100, 1'b0, 8'h0F, 64'h0);

        // A5: slave never answers -> timeout after 15 cycles of beat 0
        a_mode = 2;
        push_done(0, 64'h0, 1'b1, 1'b1, 16, 15);
        req(0, 22'h000108, 1'b0, 8'h0F, 64'h0);
        a_mode = 0;

        // B1: 64->16 little-endian write, sel 0x0C -> single beat at base+2
        push_beat(1, 22'h000302, 2'b11, 1'b1, 16'hAABB);
        push_done(1, 64'h0, 1'b0, 1'b0, 2, 1);
        req(1, 22'h000300, 1'b1, 8'h0C, 64'h0000_0000_AABB_0000);

        // B2: read with empty middle beats skipped at zero cost
        push_beat(1, 22'h000300, 2'b11, 1'b0, 16'hCDEF);
        push_beat(1, 22'h000306, 2'b11, 1'b0, 16'h0123);
        push_done(1, 64'h4444_0000_0000_1111, 1'b1, 1'b0, 3, 2);
        req(1, 22'h000300, 1'b0, 8'hC3, 64'h0123_4567_89AB_CDEF);

        // B3: reset during beat 1 of a 4-beat read
        push_beat(1, 22'h000308, 2'b11, 1'b0, 16'h0000);
        push_beat(1, 22'h00030A, 2'b11, 1'b0, 16'h0000);
        b_m_adr = 22'h000308; b_m_we = 1'b0; b_m_sel = 8'hFF; b_m_dat_w = 64'h0;
        b_m_cs = 1'b1; b_start = cyc_cnt; b_ncs_base = b_ncs;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        b_rst = 1'b1; b_m_cs = 1'b0;
        @(posedge clk);
        #1;
        b_rst = 1'b0;
        @(negedge clk);
        chk("b_reset_s_cs", 64'(b_s_cs), 64'd0);
        chk("b_reset_m_ack", 64'(b_m_ack), 64'd0);
        chk("b_reset_m_dat_r", b_m_dat_r, 64'd0);
        repeat (3) @(negedge clk);
        chk("b_reset_s_cs_idle", 64'(b_s_cs), 64'd0);
        chk("b_reset_beats_left", 64'(qb_beat.size()), 64'd0);
        @(posedge clk);
        #1;

        // B4: new request after reset completes normally
        push_beat(1, 22'h000310, 2'b11, 1'b0, 16'h3210);
        push_beat(1, 22'h000312, 2'b11, 1'b0, 16'h7654);
        push_beat(1, 22'h000314, 2'b11, 1'b0, 16'hBA98);
        push_beat(1, 22'h000316, 2'b11, 1'b0, 16'hFEDC);
        push_done(1, 64'h4444_3333_2222_1111, 1'b1, 1'b0, 5, 4);
        req(1, 22'h000310, 1'b0, 8'hFF, 64'hFEDC_BA98_7654_3210);

        repeat (3) @(negedge clk);
        chk("a_beat_q_empty", 64'(qa_beat.size()), 64'd0);
        chk("a_done_q_empty", 64'(qa_done.size()), 64'd0);
        chk("b_beat_q_empty", 64'(qb_beat.size()), 64'd0);
        chk("b_done_q_empty", 64'(qb_done.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
